// File: rtl/channel_emulator.sv
// ---------------------------------------------------------------------------
// channel_emulator
//
// Loopback channel model. Words from the tester's transmit port are queued in
// a FIFO together with a release timestamp. Each word is returned once its
// programmable latency has elapsed. On the way out it may be corrupted by an
// LFSR-driven bit-error injector. The output order is always the FIFO order.
//
// Parameters:
//   W      word width (power of two, 8..64)
//   DEPTH  FIFO entries (power of two, >= 2)
//   LAT_W  width of the free-running timestamp and of 'delay'
//
// Ports:
//   clk           single clock
//   reset         synchronous, active-high reset
//   data_in       transmit word from the tester
//   ena_data_in   one-cycle strobe, data_in valid
//   delay         latency in cycles, sampled per word at push
//   err_thr       injection threshold, compared per output word
//   data_out      word to the tester receive port (registered, holds value)
//   ena_data_out  one-cycle strobe, data_out valid (registered)
//   overflow      sticky: a word was dropped on a full FIFO
//   inj_cnt       number of injected bit errors, wraps
//   words_cnt     number of words emitted, wraps
//
// Configuration macro:
//   CHANNEL_EMU_BURST_EN  when defined, each injection flips the two adjacent
//                         bits idx and (idx+1) mod W. When undefined, only
//                         bit idx is flipped.
// ---------------------------------------------------------------------------
module channel_emulator #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int LAT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     data_in,
  input  logic             ena_data_in,
  input  logic [LAT_W-1:0] delay,
  input  logic [15:0]      err_thr,
  output logic [W-1:0]     data_out,
  output logic             ena_data_out,
  output logic             overflow,
  output logic [31:0]      inj_cnt,
  output logic [31:0]      words_cnt
);

  localparam int IDX_W = $clog2(W);
  localparam int AW    = $clog2(DEPTH);

  localparam logic [AW:0]      FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE    = (AW+1)'(1);
  localparam logic [LAT_W-1:0] DLY_MIN    = LAT_W'(1);
  localparam logic [LAT_W-1:0] DLY_MAX    = {1'b0, {(LAT_W-1){1'b1}}};
  localparam logic [LAT_W-1:0] STAMP_ONE  = LAT_W'(1);
  localparam logic [31:0]      LFSR_TAPS  = 32'hF820_0000;
  localparam logic [31:0]      LFSR_SEED  = 32'hFFFF_FFFF;
`ifdef CHANNEL_EMU_BURST_EN
  localparam logic [31:0]      INJ_BITS   = 32'd2;
`else
  localparam logic [31:0]      INJ_BITS   = 32'd1;
`endif

  // Galois-free Fibonacci step: XOR of tapped bits shifts in at bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return {cur[30:0], ^(cur & LFSR_TAPS)};
  endfunction

  // Keep the latency inside the half-range where the wrap-safe due test holds.
  function automatic logic [LAT_W-1:0] clamp_delay(input logic [LAT_W-1:0] d);
    logic [LAT_W-1:0] res;
    if (d == {LAT_W{1'b0}}) begin
      res = DLY_MIN;
    end else if (d[LAT_W-1]) begin
      res = DLY_MAX;
    end else begin
      res = d;
    end
    return res;
  endfunction

  // Error pattern for one injection event at bit position idx.
  function automatic logic [W-1:0] inj_mask(input logic [IDX_W-1:0] idx);
    logic [W-1:0] m;
`ifdef CHANNEL_EMU_BURST_EN
    logic [IDX_W-1:0] idx_nxt;
`endif
    m      = {W{1'b0}};
    m[idx] = 1'b1;
`ifdef CHANNEL_EMU_BURST_EN
    // W is a power of two, so the natural wrap of idx_nxt is mod W.
    idx_nxt    = idx + IDX_W'(1);
    m[idx_nxt] = 1'b1;
`endif
    return m;
  endfunction

  // FIFO storage: payload and absolute release timestamp per entry.
  logic [W-1:0]     mem_data_r [DEPTH];
  logic [LAT_W-1:0] mem_rel_r  [DEPTH];

  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [LAT_W-1:0] stamp_r;
  logic [31:0]      lfsr_r;

  logic [W-1:0]     data_out_r;
  logic             ena_data_out_r;
  logic             overflow_r;
  logic [31:0]      inj_cnt_r;
  logic [31:0]      words_cnt_r;

  logic [W-1:0]     head_data_s;
  logic [LAT_W-1:0] head_rel_s;
  logic [LAT_W-1:0] age_s;
  logic [LAT_W-1:0] rel_s;
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic             inject_s;
  logic [W-1:0]     mask_s;

  // Head due test, push/pop/drop decisions and the injection pattern.
  always_comb begin
    head_data_s = mem_data_r[rd_ptr_r];
    head_rel_s  = mem_rel_r[rd_ptr_r];
    // Modular difference: MSB clear means the release time has been reached.
    age_s       = stamp_r - head_rel_s;
    empty_s     = (count_r == {(AW+1){1'b0}});
    full_s      = (count_r == FULL_CNT);
    pop_s       = ~empty_s & ~age_s[LAT_W-1];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_s      = ena_data_in & (~full_s | pop_s);
    drop_s      = ena_data_in & full_s & ~pop_s;
    rel_s       = stamp_r + clamp_delay(delay);
    if (lfsr_r[31:16] < err_thr) begin
      inject_s = 1'b1;
      mask_s   = inj_mask(lfsr_r[IDX_W-1:0]);
    end else begin
      inject_s = 1'b0;
      mask_s   = {W{1'b0}};
    end
  end

  // FIFO storage write. Contents need no reset because occupancy is tracked.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_data_r[wr_ptr_r] <= data_in;
      mem_rel_r[wr_ptr_r]  <= rel_s;
    end
  end

  // Timestamp, LFSR, FIFO pointers, registered outputs and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      stamp_r        <= {LAT_W{1'b0}};
      lfsr_r         <= LFSR_SEED;
      wr_ptr_r       <= {AW{1'b0}};
      rd_ptr_r       <= {AW{1'b0}};
      count_r        <= {(AW+1){1'b0}};
      data_out_r     <= {W{1'b0}};
      ena_data_out_r <= 1'b0;
      overflow_r     <= 1'b0;
      inj_cnt_r      <= 32'd0;
      words_cnt_r    <= 32'd0;
    end else begin
      stamp_r <= stamp_r + STAMP_ONE;
      lfsr_r  <= lfsr_next(lfsr_r);

      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end

      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase

      ena_data_out_r <= pop_s;
      if (pop_s) begin
        data_out_r  <= head_data_s ^ mask_s;
        words_cnt_r <= words_cnt_r + 32'd1;
        if (inject_s) begin
          inj_cnt_r <= inj_cnt_r + INJ_BITS;
        end
      end

      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign data_out     = data_out_r;
  assign ena_data_out = ena_data_out_r;
  assign overflow     = overflow_r;
  assign inj_cnt      = inj_cnt_r;
  assign words_cnt    = words_cnt_r;

endmodule

// File: tb/tb_channel_emulator.sv
// ---------------------------------------------------------------------------
// tb_channel_emulator
//
// Self-checking bench for channel_emulator. A small reference model (timestamp
// counter, LFSR stepped from its rule, expected-word queues) predicts every
// output word, its injected error pattern, its timing and the counters.
// ---------------------------------------------------------------------------
module tb_channel_emulator;

  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int LAT_W = 16;
`ifdef CHANNEL_EMU_BURST_EN
  localparam int BITS  = 2;
`else
  localparam int BITS  = 1;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [W-1:0]     data_in = '0;
  logic             ena_data_in = 1'b0;
  logic [LAT_W-1:0] delay = '0;
  logic [15:0]      err_thr = '0;
  logic [W-1:0]     data_out;
  logic             ena_data_out;
  logic             overflow;
  logic [31:0]      inj_cnt;
  logic [31:0]      words_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Running expectations of the statistics counters.
  int unsigned exp_words = 0;
  int unsigned exp_inj   = 0;

  channel_emulator #(.W(W), .DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .ena_data_in  (ena_data_in),
    .delay        (delay),
    .err_thr      (err_thr),
    .data_out     (data_out),
    .ena_data_out (ena_data_out),
    .overflow     (overflow),
    .inj_cnt      (inj_cnt),
    .words_cnt    (words_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ^(s & 32'hF820_0000)};
  endfunction

  // Expected error pattern for a word popped while the LFSR holds l.
  function automatic logic [31:0] exp_mask(input logic [31:0] l, input logic [15:0] thr);
    logic [31:0] m;
    int idx;
    m = 32'd0;
    if (l[31:16] < thr) begin
      idx    = int'(l[4:0]);
      m[idx] = 1'b1;
`ifdef CHANNEL_EMU_BURST_EN
      m[(idx + 1) % 32] = 1'b1;
`endif
    end
    return m;
  endfunction

  // Reference timestamp and LFSR, both following the reset.
  logic [15:0] m_stamp;
  logic [31:0] m_lfsr;
  logic [31:0] lfsr_pre;
  logic [15:0] thr_pre;

  always @(posedge clk) begin
    if (reset) begin
      m_stamp <= 16'd0;
      m_lfsr  <= 32'hFFFF_FFFF;
    end else begin
      m_stamp <= m_stamp + 16'd1;
      m_lfsr  <= lfsr_step(m_lfsr);
    end
  end

  // One clock: remember the LFSR/threshold seen at the edge, sample after it.
  task automatic tick();
    lfsr_pre = m_lfsr;
    thr_pre  = err_thr;
    @(posedge clk);
    #1;
  endtask

  // Push one word and wait (bounded) for the next output strobe.
  task automatic push_wait(input logic [31:0] w, input logic [15:0] d, input int limit,
                           output int lat, output logic [31:0] dout, output logic [31:0] lpop);
    data_in     = w;
    delay       = d;
    ena_data_in = 1'b1;
    tick();
    ena_data_in = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!ena_data_out && lat < limit);
    dout = data_out;
    lpop = lfsr_pre;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp += 5;
    if (data_out !== 32'd0) begin n_bad++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
    if (ena_data_out !== 1'b0) begin n_bad++; $display("FAIL reset_ena got=%b exp=0", ena_data_out); end
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    if (inj_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_inj_cnt got=%0d exp=0", inj_cnt); end
    if (words_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_words_cnt got=%0d exp=0", words_cnt); end
    reset = 1'b0;
    exp_words = 0;
    exp_inj   = 0;
  endtask

  task automatic test_basic_latency();
    int lat;
    logic [31:0] dout, lp;
    err_thr = 16'd0;
    push_wait(32'hA5A5_A5A5, 16'd10, 40, lat, dout, lp);
    exp_words++;
    n_cmp += 4;
    if (!(ena_data_out === 1'b1 && lat == 10)) begin n_bad++; $display("FAIL basic_latency got=%0d exp=10", lat); end
    if (dout !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL basic_data got=%h exp=a5a5a5a5", dout); end
    if (inj_cnt !== 32'd0) begin n_bad++; $display("FAIL basic_inj_cnt got=%0d exp=0", inj_cnt); end
    if (words_cnt !== exp_words) begin n_bad++; $display("FAIL basic_words_cnt got=%0d exp=%0d", words_cnt, exp_words); end
    tick();
    n_cmp += 2;
    if (ena_data_out !== 1'b0) begin n_bad++; $display("FAIL basic_strobe_width got=%b exp=0", ena_data_out); end
    if (data_out !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL basic_hold got=%h exp=a5a5a5a5", data_out); end
  endtask

  // Phase 0: full-rate injection, alternating pattern, back-to-back.
  // Phase 1: random traffic, random delays and a random threshold per cycle.
  task automatic test_injection();
    logic [31:0] q[$];
    logic [31:0] r, w, m;
    int n_pushed, n_out, limit;
    for (int ph = 0; ph < 2; ph++) begin
      r        = $urandom;
      n_pushed = 0;
      n_out    = 0;
      limit    = (ph == 0) ? 1000 : 300;
      err_thr  = 16'hFFFF;
      delay    = 16'd4;
      for (int i = 0; i < 4000 && (n_pushed < limit || q.size() != 0); i++) begin
        if (ph == 1) begin
          err_thr = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 65535));
          delay   = 16'($urandom_range(1, 8));
        end
        if (n_pushed < limit && (ph == 0 || $urandom_range(0, 1) == 1)) begin
          ena_data_in = 1'b1;
          data_in     = (ph == 0) ? ((n_pushed % 2 == 1) ? ~r : r) : $urandom;
          q.push_back(data_in);
          n_pushed++;
        end else begin
          ena_data_in = 1'b0;
        end
        tick();
        if (ena_data_out) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL inj_unexpected_word got=%h exp=none", data_out);
          end else begin
            w = q.pop_front();
            m = exp_mask(lfsr_pre, thr_pre);
            exp_inj += $countones(m);
            exp_words++;
            n_out++;
            if (data_out !== (w ^ m)) begin
              n_bad++;
              $display("FAIL inj_word ph=%0d got=%h exp=%h", ph, data_out, w ^ m);
            end
            if (ph == 0) begin
              n_cmp++;
              if ($countones(data_out ^ w) != ((lfsr_pre[31:16] != 16'hFFFF) ? BITS : 0)) begin
                n_bad++;
                $display("FAIL inj_flip_count got=%0d lfsr=%h", $countones(data_out ^ w), lfsr_pre);
              end
            end
          end
        end
      end
      ena_data_in = 1'b0;
      n_cmp += 2;
      if (n_out != limit) begin n_bad++; $display("FAIL inj_out_count got=%0d exp=%0d", n_out, limit); end
      if (q.size() != 0) begin n_bad++; $display("FAIL inj_missing got=%0d exp=0", q.size()); end
    end
    err_thr = 16'd0;
    n_cmp += 2;
    if (inj_cnt !== exp_inj) begin n_bad++; $display("FAIL inj_cnt got=%0d exp=%0d", inj_cnt, exp_inj); end
    if (words_cnt !== exp_words) begin n_bad++; $display("FAIL inj_words_cnt got=%0d exp=%0d", words_cnt, exp_words); end
  endtask

  // Fill the FIFO, then push on the very cycle the head pops: nothing drops.
  task automatic test_full_push_pop();
    logic [31:0] q[$];
    logic [31:0] w;
    int k, exp_i;
    err_thr = 16'd0;
    delay   = 16'd20;
    k = 0;
    for (int i = 0; i < 60; i++) begin
      if (i < 16 || i == 20) begin
        ena_data_in = 1'b1;
        data_in     = $urandom;
        q.push_back(data_in);
      end else begin
        ena_data_in = 1'b0;
      end
      tick();
      if (ena_data_out) begin
        exp_i = (k < 16) ? 20 + k : 40;
        n_cmp += 2;
        w = (q.size() != 0) ? q.pop_front() : 32'd0;
        if (data_out !== w) begin n_bad++; $display("FAIL fullpp_data k=%0d got=%h exp=%h", k, data_out, w); end
        if (i != exp_i) begin n_bad++; $display("FAIL fullpp_time k=%0d got=%0d exp=%0d", k, i, exp_i); end
        k++;
      end
    end
    n_cmp += 2;
    if (k != 17) begin n_bad++; $display("FAIL fullpp_count got=%0d exp=17", k); end
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL fullpp_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    logic [31:0] q[$];
    logic [31:0] w;
    int k;
    err_thr = 16'd0;
    delay   = 16'd100;
    k = 0;
    for (int i = 0; i < 150; i++) begin
      if (i < 17) begin
        ena_data_in = 1'b1;
        data_in     = $urandom;
        if (i < 16) q.push_back(data_in);
      end else begin
        ena_data_in = 1'b0;
      end
      tick();
      if (i == 15) begin
        n_cmp++;
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
      if (i == 16) begin
        n_cmp++;
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
      end
      if (ena_data_out) begin
        n_cmp += 2;
        w = (q.size() != 0) ? q.pop_front() : 32'd0;
        if (data_out !== w) begin n_bad++; $display("FAIL ovf_data k=%0d got=%h exp=%h", k, data_out, w); end
        if (i != 100 + k) begin n_bad++; $display("FAIL ovf_time k=%0d got=%0d exp=%0d", k, i, 100 + k); end
        k++;
      end
    end
    n_cmp += 2;
    if (k != 16) begin n_bad++; $display("FAIL ovf_count got=%0d exp=16", k); end
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_reorder();
    logic [31:0] a, b;
    int k;
    a = $urandom;
    b = ~a;
    err_thr = 16'd0;
    k = 0;
    for (int i = 0; i < 70; i++) begin
      ena_data_in = (i < 2);
      data_in     = (i == 0) ? a : b;
      delay       = (i == 0) ? 16'd50 : 16'd5;
      tick();
      if (ena_data_out) begin
        n_cmp += 2;
        if (data_out !== ((k == 0) ? a : b)) begin
          n_bad++; $display("FAIL reorder_data k=%0d got=%h exp=%h", k, data_out, (k == 0) ? a : b);
        end
        if (i != 50 + k) begin n_bad++; $display("FAIL reorder_time k=%0d got=%0d exp=%0d", k, i, 50 + k); end
        k++;
      end
    end
    ena_data_in = 1'b0;
    n_cmp++;
    if (k != 2) begin n_bad++; $display("FAIL reorder_count got=%0d exp=2", k); end
  endtask

  task automatic test_wrap_clamp();
    int lat, guard;
    logic [31:0] dout, lp, w;
    err_thr = 16'd0;
    w = $urandom;
    push_wait(w, 16'd0, 10, lat, dout, lp);
    n_cmp += 2;
    if (!(ena_data_out === 1'b1 && lat == 1)) begin n_bad++; $display("FAIL delay0_latency got=%0d exp=1", lat); end
    if (dout !== w) begin n_bad++; $display("FAIL delay0_data got=%h exp=%h", dout, w); end
    // Push at stamp 0x7FF0 so the clamped word returns right at stamp 0xFFF0.
    guard = 0;
    while (m_stamp != 16'h7FF0 && guard < 70000) begin tick(); guard++; end
    w = $urandom;
    push_wait(w, 16'hFFFF, 16'h8100, lat, dout, lp);
    n_cmp += 2;
    if (!(ena_data_out === 1'b1 && lat == 16'h7FFF)) begin n_bad++; $display("FAIL clamp_latency got=%0d exp=%0d", lat, 16'h7FFF); end
    if (dout !== w) begin n_bad++; $display("FAIL clamp_data got=%h exp=%h", dout, w); end
    guard = 0;
    while (m_stamp != 16'hFFF0 && guard < 70000) begin tick(); guard++; end
    w = $urandom;
    push_wait(w, 16'h0040, 200, lat, dout, lp);
    n_cmp += 2;
    if (!(ena_data_out === 1'b1 && lat == 16'h40)) begin n_bad++; $display("FAIL wrap_latency got=%0d exp=%0d", lat, 16'h40); end
    if (dout !== w) begin n_bad++; $display("FAIL wrap_data got=%h exp=%h", dout, w); end
  endtask

  task automatic test_reset_midflight();
    int lat, seen;
    logic [31:0] dout, lp, w, m;
    err_thr = 16'd0;
    delay   = 16'd30;
    for (int i = 0; i < 5; i++) begin
      ena_data_in = 1'b1;
      data_in     = $urandom;
      tick();
    end
    ena_data_in = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp += 5;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    if (inj_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_inj_cnt got=%0d exp=0", inj_cnt); end
    if (words_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_words_cnt got=%0d exp=0", words_cnt); end
    if (data_out !== 32'd0) begin n_bad++; $display("FAIL rst_data_out got=%h exp=0", data_out); end
    if (ena_data_out !== 1'b0) begin n_bad++; $display("FAIL rst_ena got=%b exp=0", ena_data_out); end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ena_data_out) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL rst_flushed got=%0d exp=0", seen); end
    // With a restarted LFSR the injected pattern follows the seed sequence.
    err_thr = 16'hFFFF;
    w = $urandom;
    push_wait(w, 16'd3, 20, lat, dout, lp);
    m = exp_mask(lp, 16'hFFFF);
    tick();
    n_cmp += 4;
    if (lat != 3) begin n_bad++; $display("FAIL rst_post_latency got=%0d exp=3", lat); end
    if (dout !== (w ^ m)) begin n_bad++; $display("FAIL rst_lfsr_data got=%h exp=%h", dout, w ^ m); end
    if (inj_cnt !== 32'($countones(m))) begin n_bad++; $display("FAIL rst_post_inj got=%0d exp=%0d", inj_cnt, $countones(m)); end
    if (words_cnt !== 32'd1) begin n_bad++; $display("FAIL rst_post_words got=%0d exp=1", words_cnt); end
    err_thr = 16'd0;
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_injection();
    test_full_push_pop();
    test_overflow();
    test_reorder();
    test_wrap_clamp();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/channel_emulator.md
# channel_emulator

Loopback channel model for the es8psk test bench. It sits between the tester's transmit word port and its receive word port. Words from the tester are held in a FIFO for a programmable latency, corrupted by LFSR-driven bit-error injection at a programmable rate, and returned as receive words. The tester's bit and packet statistics therefore see a known, repeatable error profile.

## Interface
Parameters:
- `W`, 32: word width; power of two, 8..64
- `DEPTH`, 16: FIFO entries; power of two, ≥2
- `LAT_W`, 16: width of timestamp and `delay`

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high reset
- `data_in`  in  W  transmit word from tester
- `ena_data_in`  in  1  one-cycle strobe, `data_in` valid
- `delay`  in  LAT_W  latency in cycles, sampled per word at push
- `err_thr`  in  16  injection threshold per output word
- `data_out`  out  W  word to tester receive port
- `ena_data_out`  out  1  one-cycle strobe, `data_out` valid
- `overflow`  out  1  sticky: a word was dropped on a full FIFO
- `inj_cnt`  out  32  injected bit errors, wraps
- `words_cnt`  out  32  words emitted, wraps

## Operation
- Free-running timestamp `stamp` (LAT_W bits): increments every cycle and wraps mod 2^LAT_W.
- Push on `ena_data_in`: store `{data_in, rel}`, where `rel = stamp + d` mod 2^LAT_W.
  - `d` is the sampled `delay`, clamped to the range 1 .. 2^(LAT_W-1)-1.
  - `delay == 0` is treated as 1.
- Due test: the head entry is due when bit LAT_W-1 of `(stamp - rel)` is 0. This comparison is wrap-safe.
- Pop: at most one pop per cycle, and only the head. A due head pops.
- Ordering: entries behind the head wait even if their own `rel` has passed. The output is strictly in FIFO order.
- Full: a push on a full FIFO with no pop in the same cycle drops the word and sets `overflow`. A push and pop in the same cycle on a full FIFO both succeed.
- Empty: nothing pops and `ena_data_out` stays 0.
- LFSR: 32 bits, taps mask 0xF8200000, feedback = XOR of `(taps & lfsr)`, shift left, feedback into bit 0. Seed 0xFFFFFFFF. It advances every cycle, independent of traffic.
- Injection at pop:
  - Inject if `lfsr[31:16] < err_thr`. `err_thr = 0` never injects.
  - Bit index = `lfsr[log2(W)-1:0]`.
  - `data_out` = popped word XOR the injection mask.
  - `inj_cnt` adds the number of bits flipped.
- `words_cnt` increments on every `ena_data_out`.
- Reset mid-operation: the FIFO is emptied, all in-flight words are discarded, and `stamp` returns to 0.

## Timing
- Reset values: `data_out` = 0, `ena_data_out` = 0, `overflow` = 0, `inj_cnt` = 0, `words_cnt` = 0, `stamp` = 0, LFSR = 0xFFFFFFFF, FIFO empty.
- Latency: a push with `ena_data_in` high at edge t, with effective delay `d` and the FIFO otherwise idle, gives `ena_data_out` high in the cycle after edge t+d. That is exactly `d` cycles after input valid.
- Outputs are registered. `data_out` holds its last value when `ena_data_out` = 0.
- Injection uses the LFSR value present at the pop edge.
- `overflow` sets on the drop edge and clears only on `reset`.
- Back-to-back pushes with equal `delay` produce back-to-back outputs.

## Configuration
- `CHANNEL_EMU_BURST_EN` defined: each injection flips two adjacent bits, `idx` and `(idx+1) mod W`, and `inj_cnt` adds 2. This models a symbol-level error.
- Not defined: a single bit `idx` is flipped and `inj_cnt` adds 1.

## Test plan
- **Basic latency:** `delay` = 10, `err_thr` = 0, push 0xA5A5A5A5 → `ena_data_out` exactly 10 cycles later, `data_out` = 0xA5A5A5A5, `inj_cnt` = 0, `words_cnt` = 1.
- **Full injection vs model:** `err_thr` = 0xFFFF, 1000 words of alternating pattern → every output differs from its input in 1 bit (2 with the macro), except where `lfsr[31:16]` = 0xFFFF. The flipped index matches a reference LFSR model, and `inj_cnt` matches the model total.
- **Overflow:** `DEPTH` = 16, `delay` = 100, 17 consecutive pushes → `overflow` = 1 after the 17th, exactly 16 words emitted, and the 17th is absent.
- **Reordering attempt:** push A with `delay` = 50, then B with `delay` = 5 on the next cycle → A at +50, B in the following cycle, order A,B preserved.
- **Wrap and clamp:** `delay` = 0 gives latency 1. A push at `stamp` = 0xFFF0 with `delay` = 0x40 is emitted 0x40 cycles later across the timestamp wrap. `delay` = 0xFFFF clamps to 0x7FFF.
- **Reset mid-flight:** 5 words in flight, `reset` pulsed for 1 cycle → no `ena_data_out` afterwards. Counters and `overflow` are 0, and the LFSR sequence restarts from 0xFFFFFFFF.
